// File: rtl/memory_stage_if.sv
// Data-memory port between the MEM stage (master) and the data memory (slave).
// The handshake is req/gnt for the request and rvalid for load data.
interface memory_stage_if #(parameter int unsigned N = 32);
   logic         req;
   logic         we;
   logic [3:0]   be;
   logic [N-1:0] addr;
   logic [N-1:0] wdata;
   logic         gnt;
   logic         rvalid;
   logic [N-1:0] rdata;

   modport master (output req, we, be, addr, wdata, input gnt, rvalid, rdata);
   modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/memory_stage.sv
// MEM stage of the RV32 pipeline: data-memory loads/stores, lane formatting, stall request, MEM/WB registers.
// Define MISALIGN_TRAP_EN to trap misaligned H/W accesses (adds misalign_exc); otherwise low address bits are forced aligned.
module memory_stage #(
   parameter int unsigned N = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pipe_en,
   input  logic [6:0]    cwMEM,
   input  logic [N-1:0]  ALUres,
   input  logic [N-1:0]  Bout,
   input  logic [N-1:0]  NPC4_IN,
   input  logic [4:0]    Rdest_in,
   memory_stage_if.master dmem,
   output logic          stall_req,
   output logic [N-1:0]  EXMEMfwd,
   output logic [N-1:0]  wb_data,
   output logic [4:0]    wb_rd,
   output logic          wb_we
`ifdef MISALIGN_TRAP_EN
   ,
   output logic          misalign_exc
`endif
);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t       state;
   logic [N-1:0] cap_buf;

   logic         mem_rd, mem_wr, is_uns;
   logic [1:0]   size, wb_sel, off;
   logic         mem_op, trap, active, req, complete, rvalid_now;
   logic [3:0]   lanes;
   logic [N-1:0] store_data, load_fmt;

   assign mem_rd = cwMEM[6];
   assign mem_wr = cwMEM[5];
   assign size   = cwMEM[4:3];
   assign is_uns = cwMEM[2];
   assign wb_sel = cwMEM[1:0];

   // Simultaneous rd+wr is treated as a load.
   assign mem_op = mem_rd | mem_wr;

`ifdef MISALIGN_TRAP_EN
   logic misaligned;
   always_comb begin
      misaligned = 1'b0;
      case (size)
         2'b00:   misaligned = 1'b0;
         2'b01:   misaligned = ALUres[0];
         default: misaligned = (ALUres[1:0] != 2'b00);
      endcase
   end
   assign trap = mem_op & misaligned;
   assign off  = ALUres[1:0];
`else
   assign trap = 1'b0;
   always_comb begin
      off = ALUres[1:0];
      case (size)
         2'b00:   off = ALUres[1:0];
         2'b01:   off = {ALUres[1], 1'b0};
         default: off = 2'b00;
      endcase
   end
`endif

   always_comb begin
      lanes      = 4'b1111;
      store_data = Bout;
      case (size)
         2'b00: begin
            lanes      = 4'b0001 << off;
            store_data = {4{Bout[7:0]}};
         end
         2'b01: begin
            lanes      = 4'b0011 << off;
            store_data = {2{Bout[15:0]}};
         end
         default: begin
            lanes      = 4'b1111;
            store_data = Bout;
         end
      endcase
   end

   function automatic logic [N-1:0] fmt_load(input logic [N-1:0] word, input logic [1:0] sz,
                                              input logic [1:0] o, input logic uns);
      logic [N-1:0] sh;
      sh = word >> {o, 3'b000};
      case (sz)
         2'b00:   fmt_load = uns ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
         2'b01:   fmt_load = uns ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
         default: fmt_load = word;
      endcase
   endfunction

   assign load_fmt = fmt_load(dmem.rdata, size, off, is_uns);

   // Reset gates the request and stall so the reset cycle is quiet.
   assign active     = !rst && mem_op && !trap;
   assign req        = active && (state == IDLE);
   assign rvalid_now = !rst && (state == WAIT) && dmem.rvalid;
   assign complete   = (req && dmem.gnt && !mem_rd) || rvalid_now;
   assign stall_req  = active && (state != DONE) && !complete;

   assign dmem.req   = req;
   assign dmem.we    = mem_wr & ~mem_rd;
   assign dmem.be    = lanes;
   assign dmem.addr  = {ALUres[N-1:2], 2'b00};
   assign dmem.wdata = store_data;

   assign EXMEMfwd   = (wb_sel == 2'b11) ? NPC4_IN : ALUres;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cap_buf <= '0;
         wb_data <= '0;
         wb_rd   <= '0;
         wb_we   <= 1'b0;
`ifdef MISALIGN_TRAP_EN
         misalign_exc <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (req && dmem.gnt) begin
                  if (mem_rd)       state <= WAIT;
                  else if (pipe_en) state <= IDLE;
                  else              state <= DONE;
               end
            end
            WAIT: begin
               if (dmem.rvalid) begin
                  cap_buf <= load_fmt;
                  state   <= pipe_en ? IDLE : DONE;
               end
            end
            DONE: begin
               if (pipe_en) state <= IDLE;
            end
            default: state <= IDLE;
         endcase

         if (stall_req) begin
            wb_we <= 1'b0;
         end else if (pipe_en) begin
            wb_rd <= Rdest_in;
            wb_we <= (wb_sel != 2'b00) && !trap;
            case (wb_sel)
               2'b01:   wb_data <= ALUres;
               2'b10:   if (!trap) wb_data <= rvalid_now ? load_fmt : cap_buf;
               2'b11:   wb_data <= NPC4_IN;
               default: wb_data <= wb_data;
            endcase
         end

`ifdef MISALIGN_TRAP_EN
         misalign_exc <= !stall_req && pipe_en && trap;
`endif
      end
   end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: memory handshake driven step by step, MEM/WB results via scoreboard queue.
// Build with MISALIGN_TRAP_EN defined to exercise the trap variant.
module tb_memory_stage;
   logic        clk = 1'b0;
   logic        rst, pipe_en;
   logic [6:0]  cw;
   logic [31:0] alu, bout, npc4;
   logic [4:0]  rd;
   logic        stall_req, wb_we;
   logic [31:0] fwd, wb_data;
   logic [4:0]  wb_rd;
`ifdef MISALIGN_TRAP_EN
   logic        misalign_exc;
`endif

   localparam logic [6:0] CW_ALU = 7'b0_0_00_0_01;
   localparam logic [6:0] CW_JAL = 7'b0_0_00_0_11;
   localparam logic [6:0] CW_LW  = 7'b1_0_10_0_10;
   localparam logic [6:0] CW_LB  = 7'b1_0_00_0_10;
   localparam logic [6:0] CW_LBU = 7'b1_0_00_1_10;
   localparam logic [6:0] CW_LH  = 7'b1_0_01_0_10;
   localparam logic [6:0] CW_SH  = 7'b0_1_01_0_00;
   localparam logic [6:0] CW_RDB = 7'b0_0_00_0_10;

   always #5 clk = ~clk;

   memory_stage_if #(.N(32)) dmem ();

   memory_stage #(.N(32)) dut (
      .clk(clk), .rst(rst), .pipe_en(pipe_en), .cwMEM(cw), .ALUres(alu), .Bout(bout),
      .NPC4_IN(npc4), .Rdest_in(rd), .dmem(dmem), .stall_req(stall_req), .EXMEMfwd(fwd),
      .wb_data(wb_data), .wb_rd(wb_rd), .wb_we(wb_we)
`ifdef MISALIGN_TRAP_EN
      , .misalign_exc(misalign_exc)
`endif
   );

   typedef struct packed {
      logic [31:0] data;
      logic [4:0]  rd;
      logic        we;
   } wb_t;

   wb_t         exp_q[$];
   int unsigned n_pass = 0;
   int unsigned n_total = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %h, want %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic push(input logic [31:0] d, input logic [4:0] r, input logic w);
      wb_t e;
      e.data = d;
      e.rd   = r;
      e.we   = w;
      exp_q.push_back(e);
   endtask

   task automatic check_wb(input string tag);
      wb_t e;
      chk({tag, "_pending"}, 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk({tag, "_data"}, wb_data, e.data);
         chk({tag, "_rd"}, 32'(wb_rd), 32'(e.rd));
         chk({tag, "_we"}, 32'(wb_we), 32'(e.we));
      end
   endtask

   task automatic set_op(input logic [6:0] c, input logic [31:0] a, input logic [4:0] r);
      cw  = c;
      alu = a;
      rd  = r;
   endtask

   initial begin
      rst = 1'b1; pipe_en = 1'b1; cw = CW_LW; alu = 32'h100; bout = '0; npc4 = '0; rd = 5'd0;
      dmem.gnt = 1'b0; dmem.rvalid = 1'b0; dmem.rdata = '0;
      settle();
      chk("rst_req", 32'(dmem.req), 32'd0);
      chk("rst_stall", 32'(stall_req), 32'd0);
      tick();
      chk("rst_wb_data", wb_data, 32'd0);
      chk("rst_wb_rd", 32'(wb_rd), 32'd0);
      chk("rst_wb_we", 32'(wb_we), 32'd0);
`ifdef MISALIGN_TRAP_EN
      chk("rst_exc", 32'(misalign_exc), 32'd0);
`endif
      rst = 1'b0;

      // ALU op and JAL link value
      set_op(CW_ALU, 32'h55, 5'd3); settle();
      chk("alu_stall", 32'(stall_req), 32'd0);
      chk("alu_req", 32'(dmem.req), 32'd0);
      chk("alu_fwd", fwd, 32'h55);
      push(32'h55, 5'd3, 1'b1); tick(); check_wb("alu");

      set_op(CW_JAL, 32'h77, 5'd1); npc4 = 32'h1004; settle();
      chk("jal_fwd", fwd, 32'h1004);
      push(32'h1004, 5'd1, 1'b1); tick(); check_wb("jal");

      // LW 0x100, gnt two cycles late, rvalid one cycle after gnt
      set_op(CW_LW, 32'h100, 5'd5); settle();
      chk("lw_req0", 32'(dmem.req), 32'd1);
      chk("lw_addr", dmem.addr, 32'h100);
      chk("lw_we", 32'(dmem.we), 32'd0);
      chk("lw_stall0", 32'(stall_req), 32'd1);
      tick();
      chk("lw_bubble_we", 32'(wb_we), 32'd0);
      chk("lw_bubble_data", wb_data, 32'h1004);
      chk("lw_stall1", 32'(stall_req), 32'd1);
      tick();
      dmem.gnt = 1'b1; settle();
      chk("lw_req2", 32'(dmem.req), 32'd1);
      chk("lw_stall2", 32'(stall_req), 32'd1);
      tick();
      dmem.gnt = 1'b0; dmem.rvalid = 1'b1; dmem.rdata = 32'hDEADBEEF; settle();
      chk("lw_wait_req", 32'(dmem.req), 32'd0);
      chk("lw_stall3", 32'(stall_req), 32'd0);
      push(32'hDEADBEEF, 5'd5, 1'b1); tick(); check_wb("lw");
      dmem.rvalid = 1'b0;

      // LB / LBU at 0x103
      set_op(CW_LB, 32'h103, 5'd6); dmem.gnt = 1'b1; settle();
      chk("lb_stall", 32'(stall_req), 32'd1);
      tick();
      dmem.gnt = 1'b0; dmem.rvalid = 1'b1; dmem.rdata = 32'h80FF_0000;
      push(32'hFFFFFF80, 5'd6, 1'b1); tick(); check_wb("lb");
      dmem.rvalid = 1'b0;

      set_op(CW_LBU, 32'h103, 5'd6); dmem.gnt = 1'b1; tick();
      dmem.gnt = 1'b0; dmem.rvalid = 1'b1;
      push(32'h00000080, 5'd6, 1'b1); tick(); check_wb("lbu");
      dmem.rvalid = 1'b0;

      // SH 0x202, immediate grant
      set_op(CW_SH, 32'h202, 5'd7); bout = 32'h1234ABCD; dmem.gnt = 1'b1; settle();
      chk("sh_req", 32'(dmem.req), 32'd1);
      chk("sh_we", 32'(dmem.we), 32'd1);
      chk("sh_be", 32'(dmem.be), 32'b1100);
      chk("sh_wdata", dmem.wdata, 32'hABCDABCD);
      chk("sh_stall", 32'(stall_req), 32'd0);
      push(32'h80, 5'd7, 1'b0); tick(); check_wb("sh");
      dmem.gnt = 1'b0;

      // Load completes while pipe_en=0: parked in DONE, released from the capture buffer
      set_op(CW_LW, 32'h104, 5'd8); pipe_en = 1'b0; dmem.gnt = 1'b1; tick();
      dmem.gnt = 1'b0; dmem.rvalid = 1'b1; dmem.rdata = 32'hCAFEF00D; settle();
      chk("hold_stall_rv", 32'(stall_req), 32'd0);
      tick();
      dmem.rvalid = 1'b0; dmem.rdata = 32'h0; dmem.gnt = 1'b1; settle();
      chk("done_req0", 32'(dmem.req), 32'd0);
      chk("done_stall0", 32'(stall_req), 32'd0);
      tick();
      settle();
      chk("done_req1", 32'(dmem.req), 32'd0);
      chk("done_wb_we", 32'(wb_we), 32'd0);
      tick();
      pipe_en = 1'b1; settle();
      chk("done_req2", 32'(dmem.req), 32'd0);
      chk("done_stall2", 32'(stall_req), 32'd0);
      push(32'hCAFEF00D, 5'd8, 1'b1); tick(); check_wb("done");
      dmem.gnt = 1'b0;

      // Reset while in WAIT; late rvalid must not reach the capture buffer
      set_op(CW_LW, 32'h108, 5'd9); dmem.gnt = 1'b1; tick();
      dmem.gnt = 1'b0; rst = 1'b1; set_op(7'd0, 32'h0, 5'd0); settle();
      chk("rstw_stall", 32'(stall_req), 32'd0);
      tick();
      rst = 1'b0; dmem.rvalid = 1'b1; dmem.rdata = 32'h00000BAD;
      set_op(CW_RDB, 32'h0, 5'd10); settle();
      chk("rstw_req", 32'(dmem.req), 32'd0);
      chk("rstw_stall2", 32'(stall_req), 32'd0);
      chk("rstw_wb_we", 32'(wb_we), 32'd0);
      push(32'h0, 5'd10, 1'b1); tick(); check_wb("rstw_a");
      dmem.rvalid = 1'b0;
      set_op(CW_RDB, 32'h0, 5'd11);
      push(32'h0, 5'd11, 1'b1); tick(); check_wb("rstw_b");

      // Misaligned LW 0x101
      set_op(CW_LW, 32'h101, 5'd12); dmem.gnt = 1'b1; settle();
`ifdef MISALIGN_TRAP_EN
      chk("mis_req", 32'(dmem.req), 32'd0);
      chk("mis_stall", 32'(stall_req), 32'd0);
      tick();
      chk("mis_exc", 32'(misalign_exc), 32'd1);
      chk("mis_wb_we", 32'(wb_we), 32'd0);
      chk("mis_wb_rd", 32'(wb_rd), 32'd12);
      dmem.gnt = 1'b0;
`else
      chk("mis_req", 32'(dmem.req), 32'd1);
      chk("mis_addr", dmem.addr, 32'h100);
      chk("mis_stall", 32'(stall_req), 32'd1);
      tick();
      dmem.gnt = 1'b0; dmem.rvalid = 1'b1; dmem.rdata = 32'h11223344;
      push(32'h11223344, 5'd12, 1'b1); tick(); check_wb("mis_lw");
      dmem.rvalid = 1'b0;

      set_op(CW_LH, 32'h103, 5'd14); dmem.gnt = 1'b1; tick();
      dmem.gnt = 1'b0; dmem.rvalid = 1'b1; dmem.rdata = 32'h8001_0000;
      push(32'hFFFF8001, 5'd14, 1'b1); tick(); check_wb("mis_lh");
      dmem.rvalid = 1'b0;
`endif

      set_op(CW_ALU, 32'h9, 5'd13);
      push(32'h9, 5'd13, 1'b1); tick(); check_wb("post");
`ifdef MISALIGN_TRAP_EN
      chk("post_exc", 32'(misalign_exc), 32'd0);
`endif

      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
